id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection and bubble insertion.

---
 rtl/id_ex_pkg.sv | 20 ++
 rtl/id_ex_stage_load_use_detect.sv | 16 +
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle bit layout and the stall FSM encoding.
package id_ex_pkg;

    localparam int CTRL_W        = 8;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    // LSB of the two-bit ALUOP field, occupying [CTRL_ALUOP+1:CTRL_ALUOP]
    localparam int CTRL_ALUOP    = 6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare: a load in ID/EX whose destination rt is read by the instruction in IF/ID.
// Zero latency; no state, no backpressure of its own.
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hz_o
);

    assign hz_o = ex_valid_i & ex_memread_i & id_valid_i & (ex_rt_i != 5'd0)
                & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; one-cycle latency, ex_stall_i freezes it and holds PC/IF-ID.
// Optional ID_EX_STALL_CNT_EN builds a 32-bit counter of hazard bubbles; otherwise stall_cnt_o is tied to zero.
module id_ex_stage #(
    parameter int DATA_W           = 32,
    parameter int CTRL_W           = 8,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ex_stall_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [4:0]        RSaddr_o,
    output logic [4:0]        RTaddr_o,
    output logic [4:0]        RDaddr_o,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              hazard_o,
    output logic              PCWrite_o,
    output logic              IF_ID_Write_o,
    output logic [31:0]       stall_cnt_o
);
    import id_ex_pkg::*;

    state_e            state_q, state_d;
    logic [2:0]        rem_q, rem_d;
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rsd_q, rtd_q, imm_q;
    logic              hz, bubble, load, hold_front;

    load_use_detect u_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
        .ex_rt_i      (rt_q),
        .id_valid_i   (valid_i),
        .id_rs_i      (RSaddr_i),
        .id_rt_i      (RTaddr_i),
        .hz_o         (hz)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        bubble     = 1'b0;
        load       = 1'b0;
        hazard_o   = 1'b0;
        hold_front = 1'b0;
        if (flush_i) begin
            bubble  = 1'b1;
            state_d = ST_RUN;
            rem_d   = 3'd0;
        end else if (ex_stall_i) begin
            // Frozen: hazard still reports the held condition so front-end logic stays consistent.
            hold_front = 1'b1;
            hazard_o   = (state_q == ST_STALL) | hz;
        end else if (state_q == ST_RUN && hz) begin
            bubble     = 1'b1;
            hazard_o   = 1'b1;
            hold_front = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
                state_d = ST_STALL;
                rem_d   = 3'(LOAD_USE_BUBBLES - 1);
            end
        end else if (state_q == ST_STALL) begin
            bubble     = 1'b1;
            hazard_o   = 1'b1;
            hold_front = 1'b1;
            rem_d      = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end else begin
            load = 1'b1;
        end
    end

    assign PCWrite_o     = ~hold_front;
    assign IF_ID_Write_o = ~hold_front;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rsd_q   <= '0;
            rtd_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (bubble) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                rs_q    <= '0;
                rt_q    <= '0;
                rd_q    <= '0;
                rsd_q   <= '0;
                rtd_q   <= '0;
                imm_q   <= '0;
            end else if (load) begin
                valid_q <= valid_i;
                ctrl_q  <= ctrl_i;
                rs_q    <= RSaddr_i;
                rt_q    <= RTaddr_i;
                rd_q    <= RDaddr_i;
                rsd_q   <= RSdata_i;
                rtd_q   <= RTdata_i;
                imm_q   <= imm_i;
            end
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] cnt_q;

    // Flush bubbles are excluded: only hazard-generated bubbles are counted.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= 32'd0;
        end else if (bubble && !flush_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

    assign valid_o  = valid_q;
    assign ctrl_o   = ctrl_q;
    assign RSaddr_o = rs_q;
    assign RTaddr_o = rt_q;
    assign RDaddr_o = rd_q;
    assign RSdata_o = rsd_q;
    assign RTdata_o = rtd_q;
    assign imm_o    = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 3 bubbles per hazard) driven in parallel against a pending-bubble model.
module tb_id_ex_stage;
    import id_ex_pkg::*;

`ifdef ID_EX_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [7:0] LW_CTRL  = 8'h17;
    localparam logic [7:0] ADD_CTRL = 8'hA1;

    typedef struct packed {
        logic        v;
        logic [7:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  pend;
        logic [31:0] cnt;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, ex_stall, vin;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;

    logic        p1_v, p1_hz, p1_pcw, p1_ifid;
    logic [7:0]  p1_ctrl;
    logic [4:0]  p1_rs, p1_rt, p1_rd;
    logic [31:0] p1_rsd, p1_rtd, p1_imm, p1_cnt;
    logic        p3_v, p3_hz, p3_pcw, p3_ifid;
    logic [7:0]  p3_ctrl;
    logic [4:0]  p3_rs, p3_rt, p3_rd;
    logic [31:0] p3_rsd, p3_rtd, p3_imm, p3_cnt;

    logic [154:0] obs1, obs3;
    assign obs1 = {p1_v, p1_ctrl, p1_rs, p1_rt, p1_rd, p1_rsd, p1_rtd, p1_imm, p1_hz, p1_pcw, p1_ifid, p1_cnt};
    assign obs3 = {p3_v, p3_ctrl, p3_rs, p3_rt, p3_rd, p3_rsd, p3_rtd, p3_imm, p3_hz, p3_pcw, p3_ifid, p3_cnt};

    int      ntests = 0;
    int      nfail  = 0;
    mstate_t m1, m3;
    logic [31:0] cnt_base;
    int      hz_cycles;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CTRL_W(8), .LOAD_USE_BUBBLES(1)) u_b1 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .ex_stall_i(ex_stall), .valid_i(vin),
        .ctrl_i(ctrl), .RSaddr_i(rs), .RTaddr_i(rt), .RDaddr_i(rd), .RSdata_i(rsd),
        .RTdata_i(rtd), .imm_i(imm), .valid_o(p1_v), .ctrl_o(p1_ctrl), .RSaddr_o(p1_rs),
        .RTaddr_o(p1_rt), .RDaddr_o(p1_rd), .RSdata_o(p1_rsd), .RTdata_o(p1_rtd), .imm_o(p1_imm),
        .hazard_o(p1_hz), .PCWrite_o(p1_pcw), .IF_ID_Write_o(p1_ifid), .stall_cnt_o(p1_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CTRL_W(8), .LOAD_USE_BUBBLES(3)) u_b3 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .ex_stall_i(ex_stall), .valid_i(vin),
        .ctrl_i(ctrl), .RSaddr_i(rs), .RTaddr_i(rt), .RDaddr_i(rd), .RSdata_i(rsd),
        .RTdata_i(rtd), .imm_i(imm), .valid_o(p3_v), .ctrl_o(p3_ctrl), .RSaddr_o(p3_rs),
        .RTaddr_o(p3_rt), .RDaddr_o(p3_rd), .RSdata_o(p3_rsd), .RTdata_o(p3_rtd), .imm_o(p3_imm),
        .hazard_o(p3_hz), .PCWrite_o(p3_pcw), .IF_ID_Write_o(p3_ifid), .stall_cnt_o(p3_cnt)
    );

    // Reference model: a count of bubbles still owed replaces any notion of FSM state.
    function automatic logic m_dep(mstate_t m);
        return m.v && m.ctrl[CTRL_MEMREAD] && vin && (m.rt != 5'd0) && (m.rt == rs || m.rt == rt);
    endfunction

    function automatic logic m_hazard(mstate_t m);
        if (flush) return 1'b0;
        return (m.pend != 4'd0) || m_dep(m);
    endfunction

    function automatic logic [154:0] exp_vec(mstate_t m);
        logic        h, g;
        logic [31:0] c;
        h = m_hazard(m);
        g = flush || (!ex_stall && !h);
        c = CNT_ON ? m.cnt : 32'd0;
        return {m.v, m.ctrl, m.rs, m.rt, m.rd, m.rsd, m.rtd, m.imm, h, g, g, c};
    endfunction

    function automatic mstate_t m_next(mstate_t m, int n);
        mstate_t r;
        mstate_t blank;
        r = m;
        blank = '0;
        if (flush) begin
            r = blank;
            r.cnt = m.cnt;
        end else if (ex_stall) begin
            r = m;
        end else if (m.pend != 4'd0) begin
            r = blank;
            r.pend = m.pend - 4'd1;
            r.cnt = m.cnt + 32'd1;
        end else if (m_dep(m)) begin
            r = blank;
            r.pend = 4'(n - 1);
            r.cnt = m.cnt + 32'd1;
        end else begin
            r = {vin, ctrl, rs, rt, rd, rsd, rtd, imm, 4'd0, m.cnt};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m1 = m_next(m1, 1);
            m3 = m_next(m3, 3);
        end else begin
            m1 = '0;
            m3 = '0;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [7:0] c, input logic [4:0] a_rs,
                          input logic [4:0] a_rt, input logic [4:0] a_rd);
        vin = v; ctrl = c; rs = a_rs; rt = a_rt; rd = a_rd;
        rsd = $urandom; rtd = $urandom; imm = $urandom;
    endtask

    task automatic settle();
        flush = 1'b0; ex_stall = 1'b0;
        set_in(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        m1 = '0; m3 = '0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom), 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            ntests++; if (obs1 !== exp_vec(m1)) begin nfail++; $display("FAIL reset_b1 got=%h exp=%h", obs1, exp_vec(m1)); end
            ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL reset_b3 got=%h exp=%h", obs3, exp_vec(m3)); end
            ntests++; if ({p1_v, p1_hz, p1_pcw, p1_ifid, p1_cnt} !== {3'b001, 1'b1, 32'd0}) begin
                nfail++; $display("FAIL reset_const got=%b/%b/%b/%b/%0d exp=0/0/1/1/0", p1_v, p1_hz, p1_pcw, p1_ifid, p1_cnt);
            end
            tick();
        end
        rst_n = 1'b1;
        set_in(1'b1, ADD_CTRL, 5'd5, 5'd6, 5'd7);
        tick();
        #1;
        ntests++; if ({p1_v, p1_rs, p1_rt, p1_rd} !== {1'b1, 5'd5, 5'd6, 5'd7}) begin
            nfail++; $display("FAIL reset_first_capture got=%b/%0d/%0d/%0d exp=1/5/6/7", p1_v, p1_rs, p1_rt, p1_rd);
        end
    endtask

    task automatic test_load_use();
        settle();
        set_in(1'b1, LW_CTRL, 5'd1, 5'd2, 5'd0);
        tick();
        set_in(1'b1, ADD_CTRL, 5'd2, 5'd3, 5'd4);
        #1;
        ntests++; if ({p1_hz, p1_pcw, p1_ifid} !== 3'b100) begin nfail++; $display("FAIL lu_detect got=%b exp=100", {p1_hz, p1_pcw, p1_ifid}); end
        ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL lu_detect_b3 got=%h exp=%h", obs3, exp_vec(m3)); end
        tick();
        #1;
        ntests++; if ({p1_v, p1_ctrl, p1_hz, p1_pcw} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            nfail++; $display("FAIL lu_bubble got=%b/%h/%b/%b exp=0/00/0/1", p1_v, p1_ctrl, p1_hz, p1_pcw);
        end
        ntests++; if (obs1 !== exp_vec(m1)) begin nfail++; $display("FAIL lu_bubble_b1 got=%h exp=%h", obs1, exp_vec(m1)); end
        tick();
        #1;
        ntests++; if ({p1_v, p1_ctrl, p1_rs, p1_rd} !== {1'b1, ADD_CTRL, 5'd2, 5'd4}) begin
            nfail++; $display("FAIL lu_release got=%b/%h/%0d/%0d exp=1/a1/2/4", p1_v, p1_ctrl, p1_rs, p1_rd);
        end
        ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL lu_release_b3 got=%h exp=%h", obs3, exp_vec(m3)); end
    endtask

    task automatic test_multi_bubble();
        settle();
        cnt_base = p3_cnt;
        set_in(1'b1, LW_CTRL, 5'd1, 5'd7, 5'd0);
        tick();
        set_in(1'b1, ADD_CTRL, 5'd3, 5'd7, 5'd9);
        hz_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (p3_hz === 1'b1 && p3_pcw === 1'b0) hz_cycles++;
            ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL multi_cycle%0d got=%h exp=%h", i, obs3, exp_vec(m3)); end
            tick();
        end
        #1;
        ntests++; if (hz_cycles != 3) begin nfail++; $display("FAIL multi_hold_cycles got=%0d exp=3", hz_cycles); end
        ntests++; if (p3_cnt !== cnt_base + (CNT_ON ? 32'd3 : 32'd0)) begin
            nfail++; $display("FAIL multi_cnt got=%0d exp=%0d", p3_cnt, cnt_base + (CNT_ON ? 32'd3 : 32'd0));
        end
        ntests++; if ({p3_v, p3_rd} !== {1'b1, 5'd9}) begin nfail++; $display("FAIL multi_release got=%b/%0d exp=1/9", p3_v, p3_rd); end
    endtask

    task automatic test_zero_reg();
        settle();
        set_in(1'b1, LW_CTRL, 5'd1, 5'd0, 5'd0);
        tick();
        set_in(1'b1, ADD_CTRL, 5'd0, 5'd0, 5'd11);
        #1;
        ntests++; if ({p1_hz, p1_pcw, p3_hz, p3_pcw} !== 4'b0101) begin
            nfail++; $display("FAIL zero_reg_hz got=%b exp=0101", {p1_hz, p1_pcw, p3_hz, p3_pcw});
        end
        tick();
        #1;
        ntests++; if ({p3_v, p3_rd} !== {1'b1, 5'd11}) begin nfail++; $display("FAIL zero_reg_pass got=%b/%0d exp=1/11", p3_v, p3_rd); end
    endtask

    task automatic test_flush();
        settle();
        cnt_base = p3_cnt;
        set_in(1'b1, LW_CTRL, 5'd1, 5'd5, 5'd0);
        tick();
        set_in(1'b1, ADD_CTRL, 5'd5, 5'd1, 5'd2);
        flush = 1'b1;
        #1;
        ntests++; if ({p3_hz, p3_pcw, p3_ifid} !== 3'b011) begin nfail++; $display("FAIL flush_hz got=%b exp=011", {p3_hz, p3_pcw, p3_ifid}); end
        tick();
        flush = 1'b0;
        set_in(1'b1, LW_CTRL, 5'd1, 5'd6, 5'd0);
        #1;
        ntests++; if ({p3_v, p3_cnt} !== {1'b0, cnt_base}) begin nfail++; $display("FAIL flush_hz_after got=%b/%0d exp=0/%0d", p3_v, p3_cnt, cnt_base); end
        tick();
        set_in(1'b1, ADD_CTRL, 5'd6, 5'd1, 5'd2);
        tick();
        flush = 1'b1;
        #1;
        ntests++; if ({p3_hz, p3_pcw} !== 2'b01) begin nfail++; $display("FAIL flush_stall got=%b exp=01", {p3_hz, p3_pcw}); end
        tick();
        flush = 1'b0;
        set_in(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        #1;
        ntests++; if ({p3_v, p3_hz, p3_pcw} !== 3'b001 || p3_cnt !== cnt_base + (CNT_ON ? 32'd1 : 32'd0)) begin
            nfail++; $display("FAIL flush_stall_after got=%b/%0d exp=001/%0d", {p3_v, p3_hz, p3_pcw}, p3_cnt, cnt_base + (CNT_ON ? 32'd1 : 32'd0));
        end
        ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL flush_model_b3 got=%h exp=%h", obs3, exp_vec(m3)); end
    endtask

    task automatic test_ex_stall();
        settle();
        set_in(1'b1, LW_CTRL, 5'd1, 5'd9, 5'd0);
        tick();
        set_in(1'b1, ADD_CTRL, 5'd9, 5'd2, 5'd13);
        tick();
        tick();
        ex_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            ntests++; if ({p3_v, p3_hz, p3_pcw} !== 3'b010) begin nfail++; $display("FAIL exstall_frozen%0d got=%b exp=010", i, {p3_v, p3_hz, p3_pcw}); end
            ntests++; if (obs1 !== exp_vec(m1)) begin nfail++; $display("FAIL exstall_b1_%0d got=%h exp=%h", i, obs1, exp_vec(m1)); end
            tick();
        end
        ex_stall = 1'b0;
        #1;
        ntests++; if ({p3_hz, p3_pcw} !== 2'b10) begin nfail++; $display("FAIL exstall_last_bubble got=%b exp=10", {p3_hz, p3_pcw}); end
        tick();
        #1;
        ntests++; if ({p3_v, p3_hz, p3_pcw} !== 3'b001) begin nfail++; $display("FAIL exstall_run got=%b exp=001", {p3_v, p3_hz, p3_pcw}); end
        tick();
        #1;
        ntests++; if ({p3_v, p3_rs, p3_rd} !== {1'b1, 5'd9, 5'd13}) begin
            nfail++; $display("FAIL exstall_release got=%b/%0d/%0d exp=1/9/13", p3_v, p3_rs, p3_rd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush    = ($urandom_range(0, 15) == 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, 8'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                m1 = '0;
                m3 = '0;
            end else begin
                rst_n = 1'b1;
            end
            #1;
            ntests++; if (obs1 !== exp_vec(m1)) begin nfail++; $display("FAIL random_b1 cyc=%0d got=%h exp=%h", i, obs1, exp_vec(m1)); end
            ntests++; if (obs3 !== exp_vec(m3)) begin nfail++; $display("FAIL random_b3 cyc=%0d got=%h exp=%h", i, obs3, exp_vec(m3)); end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        set_in(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_multi_bubble();
        test_zero_reg();
        test_flush();
        test_ex_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
